// File: rtl/gshare_predictor_pkg.sv
// Shared sizing defaults and helpers for the gshare branch predictor.
// The default sizes below are the ones the rest of the core builds against.
package gshare_predictor_pkg;

    localparam int PREDICTOR_SIZE_WIDTH = 10;
    localparam int PREDICTOR_HIST_LEN   = 8;
    localparam int PREDICTOR_CNT_WIDTH  = 2;

    localparam int MODE_BIMODAL = 0;
    localparam int MODE_GSHARE  = 1;

    // One saturating step of a counter up to 4 bits wide; never wraps.
    function automatic logic [3:0] sat_step(
        input logic [3:0] cnt,
        input logic [3:0] cnt_max,
        input logic       taken
    );
        logic [3:0] next;
        next = cnt;
        if (taken && (cnt != cnt_max)) begin
            next = cnt + 4'd1;
        end else if (!taken && (cnt != 4'd0)) begin
            next = cnt - 4'd1;
        end
        return next;
    endfunction

endpackage

// File: rtl/gshare_predictor_pred_index.sv
// Counter-table index: word PC bits, optionally XORed with global history.
// Instantiated once for the predict path and once for the commit path.
module pred_index
    import gshare_predictor_pkg::*;
#(
    parameter int TABLE_BITS = PREDICTOR_SIZE_WIDTH,
    parameter int HIST_LEN   = PREDICTOR_HIST_LEN,
    parameter int MODE       = MODE_GSHARE
) (
    input  logic [31:0]           i_addr,
    input  logic [HIST_LEN-1:0]   i_ghr,
    output logic [TABLE_BITS-1:0] o_idx
);

    logic [TABLE_BITS-1:0] w_pc_bits;
    logic [TABLE_BITS-1:0] w_hist_ext;
    logic                  w_unused;

    assign w_pc_bits  = i_addr[TABLE_BITS+1:2];
    assign w_hist_ext = TABLE_BITS'(i_ghr);

    assign o_idx = (MODE == MODE_BIMODAL) ? w_pc_bits : (w_pc_bits ^ w_hist_ext);

    // Byte-offset and high PC bits never reach the table.
    assign w_unused = ^{i_addr[31:TABLE_BITS+2], i_addr[1:0]};

endmodule

// File: rtl/gshare_predictor.sv
// Gshare / bimodal direction predictor with speculative global history,
// ROB-driven counter training, history repair on mispredict and perf counters.
module gshare_predictor
    import gshare_predictor_pkg::*;
#(
    parameter int TABLE_BITS = PREDICTOR_SIZE_WIDTH,
    parameter int CNT_WIDTH  = PREDICTOR_CNT_WIDTH,
    parameter int HIST_LEN   = PREDICTOR_HIST_LEN,
    parameter int MODE       = MODE_GSHARE
) (
    input  logic                clk_in,
    input  logic                rst_in,
    input  logic                rdy_in,
    input  logic [31:0]         pc_in,
    output logic                pred2if_result,
    output logic [HIST_LEN-1:0] pred2if_ghr,
    input  logic                if2pred_valid,
    input  logic                if2pred_taken,
    input  logic                rob_valid,
    input  logic [31:0]         rob_instr_addr,
    input  logic                rob_is_jump,
    input  logic [HIST_LEN-1:0] rob_ghr,
    input  logic                rob_mispredict,
    output logic [31:0]         perf_branches,
    output logic [31:0]         perf_mispredicts
);

    localparam int                   ENTRIES  = 1 << TABLE_BITS;
    localparam logic [CNT_WIDTH-1:0] CNT_MAX  = '1;
    localparam logic [CNT_WIDTH-1:0] CNT_INIT = CNT_WIDTH'((1 << (CNT_WIDTH - 1)) - 1);

    logic [CNT_WIDTH-1:0]  r_table [ENTRIES];
    logic [HIST_LEN-1:0]   r_spec_ghr;
    logic [31:0]           r_perf_branches;
    logic [31:0]           r_perf_mispredicts;

    logic [TABLE_BITS-1:0] w_pred_idx;
    logic [TABLE_BITS-1:0] w_upd_idx;
    logic [CNT_WIDTH-1:0]  w_upd_cnt;
    logic [CNT_WIDTH-1:0]  w_upd_next;
    logic [HIST_LEN-1:0]   w_ghr_restore;
    logic [HIST_LEN-1:0]   w_ghr_shift;
    logic [HIST_LEN-1:0]   w_ghr_next;

    pred_index #(
        .TABLE_BITS (TABLE_BITS),
        .HIST_LEN   (HIST_LEN),
        .MODE       (MODE)
    ) u_pred_index (
        .i_addr (pc_in),
        .i_ghr  (r_spec_ghr),
        .o_idx  (w_pred_idx)
    );

    pred_index #(
        .TABLE_BITS (TABLE_BITS),
        .HIST_LEN   (HIST_LEN),
        .MODE       (MODE)
    ) u_upd_index (
        .i_addr (rob_instr_addr),
        .i_ghr  (rob_ghr),
        .o_idx  (w_upd_idx)
    );

    // Reads the registered table, so a same-cycle commit is not visible yet.
    assign pred2if_result   = r_table[w_pred_idx][CNT_WIDTH-1];
    assign pred2if_ghr      = r_spec_ghr;
    assign perf_branches    = r_perf_branches;
    assign perf_mispredicts = r_perf_mispredicts;

    assign w_upd_cnt  = r_table[w_upd_idx];
    assign w_upd_next = CNT_WIDTH'(sat_step(4'(w_upd_cnt), 4'(CNT_MAX), rob_is_jump));

    generate
        if (HIST_LEN == 1) begin : g_hist_one
            assign w_ghr_restore = rob_is_jump;
            assign w_ghr_shift   = if2pred_taken;
        end else begin : g_hist_many
            assign w_ghr_restore = {rob_ghr[HIST_LEN-2:0], rob_is_jump};
            assign w_ghr_shift   = {r_spec_ghr[HIST_LEN-2:0], if2pred_taken};
        end
    endgenerate

    // NOTE: every path assigns w_ghr_next because the default comes first; no latch.
    always_comb begin
        w_ghr_next = r_spec_ghr;
        if (MODE == MODE_BIMODAL) begin
            w_ghr_next = '0;
        end else if (rob_valid && rob_mispredict) begin
            w_ghr_next = w_ghr_restore;
        end else if (if2pred_valid) begin
            w_ghr_next = w_ghr_shift;
        end
    end

    // NOTE: state uses <= so every register samples pre-edge values of the others.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            // NOTE: the table is built from flops precisely so that all entries reset in one edge.
            for (int i = 0; i < ENTRIES; i++) begin
                r_table[i] <= CNT_INIT;
            end
            r_spec_ghr         <= '0;
            r_perf_branches    <= '0;
            r_perf_mispredicts <= '0;
        end else if (rdy_in) begin
            if (rob_valid) begin
                r_table[w_upd_idx] <= w_upd_next;
                r_perf_branches    <= r_perf_branches + 32'd1;
                if (rob_mispredict) begin
                    r_perf_mispredicts <= r_perf_mispredicts + 32'd1;
                end
            end
            r_spec_ghr <= w_ghr_next;
        end
    end

endmodule

// File: tb/tb_gshare_predictor.sv
// Bench for gshare_predictor: one gshare and one bimodal instance share stimulus
// and are compared every cycle against an arithmetic model of the predictor.
module tb_gshare_predictor;

    localparam int          TB_TABLE_BITS = 5;
    localparam int          TB_CNT_WIDTH  = 2;
    localparam int          TB_HIST_LEN   = 4;
    localparam int unsigned ENTRIES       = 32;
    localparam int unsigned CNT_TOP       = 3;
    localparam int unsigned TAKEN_MIN     = 2;
    localparam int unsigned CNT_RESET     = 1;
    localparam int unsigned HMASK         = 15;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        rdy_in;
    logic [31:0] pc_in;
    logic        if2pred_valid;
    logic        if2pred_taken;
    logic        rob_valid;
    logic [31:0] rob_instr_addr;
    logic        rob_is_jump;
    logic [3:0]  rob_ghr;
    logic        rob_mispredict;

    logic        g_result, b_result;
    logic [3:0]  g_ghr, b_ghr;
    logic [31:0] g_br, g_mp, b_br, b_mp;

    always #5 clk_in = ~clk_in;

    gshare_predictor #(
        .TABLE_BITS (TB_TABLE_BITS), .CNT_WIDTH (TB_CNT_WIDTH),
        .HIST_LEN   (TB_HIST_LEN),   .MODE      (1)
    ) u_gshare (
        .clk_in (clk_in), .rst_in (rst_in), .rdy_in (rdy_in), .pc_in (pc_in),
        .pred2if_result (g_result), .pred2if_ghr (g_ghr),
        .if2pred_valid (if2pred_valid), .if2pred_taken (if2pred_taken),
        .rob_valid (rob_valid), .rob_instr_addr (rob_instr_addr),
        .rob_is_jump (rob_is_jump), .rob_ghr (rob_ghr),
        .rob_mispredict (rob_mispredict),
        .perf_branches (g_br), .perf_mispredicts (g_mp)
    );

    gshare_predictor #(
        .TABLE_BITS (TB_TABLE_BITS), .CNT_WIDTH (TB_CNT_WIDTH),
        .HIST_LEN   (TB_HIST_LEN),   .MODE      (0)
    ) u_bimodal (
        .clk_in (clk_in), .rst_in (rst_in), .rdy_in (rdy_in), .pc_in (pc_in),
        .pred2if_result (b_result), .pred2if_ghr (b_ghr),
        .if2pred_valid (if2pred_valid), .if2pred_taken (if2pred_taken),
        .rob_valid (rob_valid), .rob_instr_addr (rob_instr_addr),
        .rob_is_jump (rob_is_jump), .rob_ghr (rob_ghr),
        .rob_mispredict (rob_mispredict),
        .perf_branches (b_br), .perf_mispredicts (b_mp)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, req, $time);
        end
    endtask

    // Reference model: plain integers, one table per mode, one shared history.
    int unsigned m_g_tab [ENTRIES];
    int unsigned m_b_tab [ENTRIES];
    int unsigned m_ghr;
    int unsigned m_br;
    int unsigned m_mp;
    bit          m_valid = 1'b0;

    function automatic int unsigned sat(input int unsigned c, input logic taken);
        if (taken) return (c == CNT_TOP) ? c : c + 1;
        return (c == 0) ? c : c - 1;
    endfunction

    task model_reset();
        for (int i = 0; i < int'(ENTRIES); i++) begin
            m_g_tab[i] = CNT_RESET;
            m_b_tab[i] = CNT_RESET;
        end
        m_ghr   = 0;
        m_br    = 0;
        m_mp    = 0;
        m_valid = 1'b1;
    endtask

    task model_step();
        int unsigned gi, bi;
        if (rob_valid) begin
            gi = ((rob_instr_addr >> 2) ^ 32'(rob_ghr)) % ENTRIES;
            bi = (rob_instr_addr >> 2) % ENTRIES;
            m_g_tab[gi] = sat(m_g_tab[gi], rob_is_jump);
            m_b_tab[bi] = sat(m_b_tab[bi], rob_is_jump);
            m_br = m_br + 1;
            if (rob_mispredict) m_mp = m_mp + 1;
        end
        if (rob_valid && rob_mispredict)
            m_ghr = ((32'(rob_ghr) << 1) | 32'(rob_is_jump)) & HMASK;
        else if (if2pred_valid)
            m_ghr = ((m_ghr << 1) | 32'(if2pred_taken)) & HMASK;
    endtask

    // Inputs only change just after a rising edge, so the falling edge sees
    // exactly the values the next rising edge will capture.
    always @(negedge clk_in) begin
        int unsigned gi, bi;
        if (m_valid) begin
            gi = ((pc_in >> 2) ^ m_ghr) % ENTRIES;
            bi = (pc_in >> 2) % ENTRIES;
            check("cyc_g_result", 32'(g_result), 32'(m_g_tab[gi] >= TAKEN_MIN));
            check("cyc_b_result", 32'(b_result), 32'(m_b_tab[bi] >= TAKEN_MIN));
            check("cyc_g_ghr",    32'(g_ghr),    m_ghr);
            check("cyc_b_ghr",    32'(b_ghr),    32'd0);
            check("cyc_g_br",     g_br,          m_br);
            check("cyc_g_mp",     g_mp,          m_mp);
            check("cyc_b_br",     b_br,          m_br);
            check("cyc_b_mp",     b_mp,          m_mp);
        end
        if (rst_in) model_reset();
        else if (m_valid && rdy_in) model_step();
    end

    task automatic idle();
        rst_in         = 1'b0;
        rdy_in         = 1'b1;
        if2pred_valid  = 1'b0;
        if2pred_taken  = 1'b0;
        rob_valid      = 1'b0;
        rob_instr_addr = 32'h0;
        rob_is_jump    = 1'b0;
        rob_ghr        = 4'h0;
        rob_mispredict = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
        idle();
        #1;
    endtask

    task automatic commit(input logic [31:0] addr, input logic [3:0] ghr,
                          input logic jump, input logic misp);
        rob_valid      = 1'b1;
        rob_instr_addr = addr;
        rob_ghr        = ghr;
        rob_is_jump    = jump;
        rob_mispredict = misp;
        tick();
    endtask

    task automatic if_shift(input logic taken);
        if2pred_valid = 1'b1;
        if2pred_taken = taken;
        tick();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        idle();
        pc_in  = 32'h0;
        rst_in = 1'b1;
        repeat (2) @(posedge clk_in);
        #1;
        idle();
        pc_in = 32'h100;
        #1;

        // Reset state.
        check("rst_g_result", 32'(g_result), 32'd0);
        check("rst_b_result", 32'(b_result), 32'd0);
        check("rst_g_ghr",    32'(g_ghr),    32'd0);
        check("rst_g_br",     g_br,          32'd0);
        check("rst_g_mp",     g_mp,          32'd0);
        check("model_rst_entry", m_b_tab[0], 32'd1);

        // Commit indexes through rob_ghr: entry 5^5=0 trains, entry 5 does not.
        commit(32'h14, 4'h5, 1'b1, 1'b0);
        pc_in = 32'h0;
        #1;
        check("upd_rob_ghr_entry", 32'(g_result), 32'd1);
        pc_in = 32'h14;
        #1;
        check("upd_not_spec_entry", 32'(g_result), 32'd0);
        check("bimodal_entry5",     32'(b_result), 32'd1);

        // Bimodal saturation at 0x100: 1 -> 2 -> 3 -> 3.
        pc_in = 32'h100;
        commit(32'h100, 4'h0, 1'b1, 1'b0);
        check("sat_first_commit", 32'(b_result), 32'd1);
        commit(32'h100, 4'h0, 1'b1, 1'b0);
        commit(32'h100, 4'h0, 1'b1, 1'b0);
        check("model_sat_entry", m_b_tab[0], 32'd3);
        check("sat_b_result",    32'(b_result), 32'd1);
        check("sat_g_br",        g_br, 32'd4);

        // Speculative shifts then ROB repair.
        if_shift(1'b1);
        if_shift(1'b1);
        if_shift(1'b0);
        check("ghr_after_shifts", 32'(g_ghr), 32'h6);
        check("bimodal_ghr_zero", 32'(b_ghr), 32'h0);
        commit(32'h200, 4'h3, 1'b1, 1'b1);
        check("ghr_repaired", 32'(g_ghr), 32'h7);
        check("misp_count1",  g_mp, 32'd1);
        check("br_count5",    g_br, 32'd5);

        // Mispredict and IF shift together: repair wins.
        rob_valid      = 1'b1;
        rob_instr_addr = 32'h200;
        rob_ghr        = 4'hA;
        rob_is_jump    = 1'b0;
        rob_mispredict = 1'b1;
        if2pred_valid  = 1'b1;
        if2pred_taken  = 1'b1;
        tick();
        check("ghr_repair_wins", 32'(g_ghr), 32'h4);
        check("misp_count2",     g_mp, 32'd2);
        check("b_misp_count2",   b_mp, 32'd2);

        // rdy_in low freezes everything, including a not-taken on entry 5.
        rdy_in         = 1'b0;
        rob_valid      = 1'b1;
        rob_instr_addr = 32'h14;
        rob_ghr        = 4'hF;
        rob_is_jump    = 1'b0;
        rob_mispredict = 1'b1;
        if2pred_valid  = 1'b1;
        if2pred_taken  = 1'b1;
        tick();
        pc_in = 32'h14;
        #1;
        check("hold_ghr",      32'(g_ghr), 32'h4);
        check("hold_br",       g_br, 32'd6);
        check("hold_mp",       g_mp, 32'd2);
        check("hold_b_br",     b_br, 32'd6);
        check("hold_b_entry5", 32'(b_result), 32'd1);

        // Mispredict without rob_valid is ignored.
        rob_mispredict = 1'b1;
        rob_ghr        = 4'hF;
        rob_is_jump    = 1'b1;
        tick();
        check("lone_misp_ghr", 32'(g_ghr), 32'h4);
        check("lone_misp_mp",  g_mp, 32'd2);

        // Reset beats same-cycle updates.
        rst_in         = 1'b1;
        rob_valid      = 1'b1;
        rob_instr_addr = 32'h100;
        rob_ghr        = 4'hF;
        rob_is_jump    = 1'b1;
        rob_mispredict = 1'b1;
        if2pred_valid  = 1'b1;
        if2pred_taken  = 1'b1;
        tick();
        pc_in = 32'h100;
        #1;
        check("rst2_ghr",      32'(g_ghr), 32'h0);
        check("rst2_br",       g_br, 32'd0);
        check("rst2_mp",       g_mp, 32'd0);
        check("rst2_b_result", 32'(b_result), 32'd0);
        check("rst2_g_result", 32'(g_result), 32'd0);

        // Randomized traffic, checked every cycle by the model.
        for (int c = 0; c < 3000; c++) begin
            rst_in         = ($urandom_range(0, 299) == 0);
            rdy_in         = ($urandom_range(0, 9) != 0);
            pc_in          = $urandom;
            if2pred_valid  = ($urandom_range(0, 1) == 1);
            if2pred_taken  = ($urandom_range(0, 1) == 1);
            rob_valid      = ($urandom_range(0, 9) < 5);
            rob_instr_addr = $urandom;
            rob_is_jump    = ($urandom_range(0, 3) != 0);
            rob_ghr        = 4'($urandom);
            rob_mispredict = ($urandom_range(0, 3) == 0);
            @(posedge clk_in);
            #1;
        end
        idle();
        repeat (3) @(posedge clk_in);
        #1;

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/gshare_predictor.md
GSHARE_PREDICTOR -- requirements
Module: gshare_predictor

Interface
REQ-001 Parameter TABLE_BITS, default `PREDICTOR_SIZE_WIDTH, log2 of counter-table entries (range 2..12).
REQ-002 Parameter CNT_WIDTH, default 2, saturating-counter width (range 1..4).
REQ-003 Parameter HIST_LEN, default 8, global-history length (range 1..TABLE_BITS).
REQ-004 Parameter MODE, default 1; 0 = bimodal (history ignored), 1 = gshare.
REQ-005 clk_in  input  1  single clock; all state updates on rising edge.
REQ-006 rst_in  input  1  reset, synchronous, active-high.
REQ-007 rdy_in  input  1  global enable; low freezes all state.
REQ-008 pc_in  input  32  fetch PC for the combinational prediction.
REQ-009 pred2if_result  output  1  predicted direction for pc_in, 1 = taken.
REQ-010 pred2if_ghr  output  HIST_LEN  speculative history snapshot, carried by IF to the ROB.
REQ-011 if2pred_valid  input  1  IF has consumed a prediction for a conditional branch.
REQ-012 if2pred_taken  input  1  direction IF actually followed for that branch.
REQ-013 rob_valid  input  1  ROB commits a conditional branch.
REQ-014 rob_instr_addr  input  32  PC of the committed branch.
REQ-015 rob_is_jump  input  1  resolved direction, 1 = taken.
REQ-016 rob_ghr  input  HIST_LEN  snapshot captured at the branch's prediction.
REQ-017 rob_mispredict  input  1  committed branch was mispredicted; pipeline flushes.
REQ-018 perf_branches  output  32  committed-branch count.
REQ-019 perf_mispredicts  output  32  mispredicted-branch count.

Function
REQ-020 Index: MODE 1 = ((addr>>2) XOR zero-extended history) mod 2^TABLE_BITS; MODE 0 = (addr>>2) mod 2^TABLE_BITS.
REQ-021 Predict path purely combinational: index from pc_in and spec_ghr; pred2if_result = MSB of the indexed counter; zero latency.
REQ-022 pred2if_ghr equals spec_ghr at all times (value before any shift this cycle).
REQ-023 Update path index from rob_instr_addr and rob_ghr, never spec_ghr.
REQ-024 On rob_valid: taken increments the counter unless at 2^CNT_WIDTH-1; not-taken decrements unless 0; no wrap in either direction.
REQ-025 spec_ghr update, priority order: rob_valid && rob_mispredict -> {rob_ghr[HIST_LEN-2:0], rob_is_jump}; else if2pred_valid -> {spec_ghr[HIST_LEN-2:0], if2pred_taken}; else hold. For HIST_LEN=1, the shifted value is the new bit alone.
REQ-026 Mispredict and if2pred_valid in the same cycle: mispredict wins and the IF shift is discarded.
REQ-027 rob_mispredict without rob_valid is ignored.
REQ-028 MODE 0: spec_ghr is held at 0 regardless of inputs.
REQ-029 Same-cycle predict and update of one entry: prediction returns the pre-update value.
REQ-030 perf_branches increments on each rob_valid; perf_mispredicts increments on rob_valid && rob_mispredict; both wrap modulo 2^32.
REQ-031 rdy_in low: table, spec_ghr and perf counters hold; the combinational prediction stays live.

Reset
REQ-032 On rst_in high at a clock edge, every counter becomes weakly-not-taken, 2^(CNT_WIDTH-1)-1 (0 when CNT_WIDTH=1).
REQ-033 Reset clears spec_ghr, perf_branches and perf_mispredicts to 0, so pred2if_result = 0 and pred2if_ghr = 0 after reset.
REQ-034 rst_in overrides rdy_in and all update inputs in the same cycle; a reset mid-operation discards in-flight updates.

Structure
REQ-035 Default sizes (`PREDICTOR_SIZE_WIDTH, `PREDICTOR_HIST_LEN, `PREDICTOR_CNT_WIDTH) live in src/const_param.v.
REQ-036 One combinational sub-module, pred_index, implements REQ-020 and is instantiated twice (predict and update paths).

Verification
REQ-037 Reset, then pc_in=0x100 -> pred2if_result=0 and pred2if_ghr=0; with CNT_WIDTH=2, entry value is 1.
REQ-038 MODE 0: three taken commits at 0x100 -> counter 1->2->3->3 (saturates); pred2if_result turns 1 after the first commit.
REQ-039 MODE 1, HIST_LEN=4: if2pred_valid with taken=1,1,0 -> pred2if_ghr=0b0110; then rob_mispredict with rob_ghr=0b0011 and rob_is_jump=1 -> 0b0111.
REQ-040 Mispredict and if2pred_valid in the same cycle -> spec_ghr takes only the ROB-restored value; perf_mispredicts +1.
REQ-041 Update with rob_ghr=0x05 at addr 0x14 modifies entry 0x05^0x05=0, not the spec_ghr-derived entry.
REQ-042 rdy_in=0 with rob_valid and if2pred_valid asserted -> counters, spec_ghr and perf counters unchanged.
